// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART multi-channel pattern controller.
// Holds the frame delimiters, the frame length, the parser and receiver
// state encodings, and the committed-command payload struct.
package uart_ctrl_pkg;

    localparam int unsigned FRAME_LEN = 9;

    localparam logic [7:0] HDR0 = 8'h55;
    localparam logic [7:0] HDR1 = 8'hA5;
    localparam logic [7:0] TAIL = 8'hF0;

    localparam int unsigned PS_W = $clog2(FRAME_LEN);

    // One parser state per frame byte position.
    typedef enum logic [PS_W-1:0] {
        PS_IDLE,
        PS_HDR2,
        PS_CH,
        PS_PAT,
        PS_T3,
        PS_T2,
        PS_T1,
        PS_T0,
        PS_TAIL
    } parse_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    // Channel configuration carried from the parser into a channel on commit.
    typedef struct packed {
        logic [7:0]  pattern;
        logic [31:0] period;
    } chan_cfg_t;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART byte receiver.
// Ports: clk, reset (async, active-high), rx (raw serial line, idle high);
//        data[7:0] received byte, valid one-cycle pulse with data,
//        err one-cycle pulse when the stop bit samples low.
module uart_rx_core
    import uart_ctrl_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       err
);

    localparam int unsigned HALF  = BAUD_DIV / 2;
    localparam int unsigned CNT_W = $clog2(BAUD_DIV + 1);

    logic            sync1_q, sync2_q, prev_q;
    rx_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;

    // Bit-timing state machine; all sampling uses the synchronised line.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                // Only a genuine 1->0 transition starts a byte, so a line
                // stuck low after a bad stop bit cannot retrigger.
                if (prev_q && !sync2_q) state_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == CNT_W'(HALF - 1)) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sync2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == CNT_W'(BAUD_DIV - 1)) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == CNT_W'(BAUD_DIV - 1)) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    if (sync2_q) begin
                        valid_d = 1'b1;
                        data_d  = shift_q;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign data  = data_q;
    assign valid = valid_q;
    assign err   = err_q;

endmodule

// File: rtl/uart_multi_ctrl.sv
// UART-commanded multi-channel pattern generator.
// Receives 9-byte frames (55 A5 ch pat t3 t2 t1 t0 F0) and loads the
// addressed channel, which then steps through pattern bits LSB first,
// holding each bit for 'period' cycles.
// Ports: clk, reset (async, active-high), uart_rx (8N1 serial in);
//        signal[CH_NUM-1:0] per-channel outputs, cmd_done commit pulse,
//        frame_err reject pulse.
module uart_multi_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int unsigned CH_NUM       = 4,
    parameter int unsigned BAUD_DIV     = 434,
    parameter int unsigned IDLE_TIMEOUT = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              uart_rx,
    output logic [CH_NUM-1:0] signal,
    output logic              cmd_done,
    output logic              frame_err
);

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;

    uart_rx_core #(
        .BAUD_DIV (BAUD_DIV)
    ) u_rx (
        .clk   (clk),
        .reset (reset),
        .rx    (uart_rx),
        .data  (rx_data),
        .valid (rx_valid),
        .err   (rx_err)
    );

    parse_state_e ps_q, ps_d;
    logic [7:0]   ch_q, ch_d;
    chan_cfg_t    cfg_q, cfg_d;
    logic [31:0]  tmo_q, tmo_d;
    logic         cmd_done_q, cmd_done_d;
    logic         frame_err_q, frame_err_d;
    logic         commit_c;
    logic         ch_ok_c;

    assign ch_ok_c = ({24'd0, ch_q} < CH_NUM);

    // Frame parser with inter-byte silence timeout.
    always_comb begin
        ps_d        = ps_q;
        ch_d        = ch_q;
        cfg_d       = cfg_q;
        tmo_d       = '0;
        cmd_done_d  = 1'b0;
        frame_err_d = 1'b0;
        commit_c    = 1'b0;
        if (rx_err) begin
            // A corrupted byte invalidates any frame in progress.
            frame_err_d = 1'b1;
            ps_d        = PS_IDLE;
        end else if (rx_valid) begin
            case (ps_q)
                PS_IDLE: if (rx_data == HDR0) ps_d = PS_HDR2;
                PS_HDR2: begin
                    if (rx_data == HDR1)      ps_d = PS_CH;
                    else if (rx_data != HDR0) ps_d = PS_IDLE;
                end
                PS_CH: begin
                    ch_d = rx_data;
                    ps_d = PS_PAT;
                end
                PS_PAT: begin
                    cfg_d.pattern = rx_data;
                    ps_d          = PS_T3;
                end
                PS_T3: begin
                    cfg_d.period[31:24] = rx_data;
                    ps_d                = PS_T2;
                end
                PS_T2: begin
                    cfg_d.period[23:16] = rx_data;
                    ps_d                = PS_T1;
                end
                PS_T1: begin
                    cfg_d.period[15:8] = rx_data;
                    ps_d               = PS_T0;
                end
                PS_T0: begin
                    cfg_d.period[7:0] = rx_data;
                    ps_d              = PS_TAIL;
                end
                PS_TAIL: begin
                    ps_d = PS_IDLE;
                    if (rx_data == TAIL && ch_ok_c) begin
                        cmd_done_d = 1'b1;
                        commit_c   = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: ps_d = PS_IDLE;
            endcase
        end else if (ps_q != PS_IDLE) begin
            if (tmo_q == 32'(IDLE_TIMEOUT - 1)) begin
                ps_d        = PS_IDLE;
                frame_err_d = 1'b1;
            end else begin
                tmo_d = tmo_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps_q        <= PS_IDLE;
            ch_q        <= '0;
            cfg_q       <= '0;
            tmo_q       <= '0;
            cmd_done_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            ps_q        <= ps_d;
            ch_q        <= ch_d;
            cfg_q       <= cfg_d;
            tmo_q       <= tmo_d;
            cmd_done_q  <= cmd_done_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign cmd_done  = cmd_done_q;
    assign frame_err = frame_err_q;

    // Per-channel step counters; only the addressed channel reacts to a commit.
    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        logic [7:0]  pat_q, pat_d;
        logic [31:0] per_q, per_d;
        logic [31:0] cnt_q, cnt_d;
        logic [2:0]  idx_q, idx_d;
        logic        sig_q, sig_d;
        logic        load_c;

        always_comb begin
            load_c = commit_c && (ch_q == 8'(i));
            pat_d  = pat_q;
            per_d  = per_q;
            cnt_d  = cnt_q;
            idx_d  = idx_q;
            // Output lags the index by one register so a new command shows
            // pattern[0] from the cycle after cmd_done.
            sig_d  = (per_q != 32'd0) ? pat_q[idx_q] : 1'b0;
            if (load_c) begin
                pat_d = cfg_q.pattern;
                per_d = cfg_q.period;
                cnt_d = '0;
                idx_d = '0;
            end else if (per_q == 32'd0) begin
                cnt_d = '0;
                idx_d = '0;
            end else if (cnt_q == per_q - 32'd1) begin
                cnt_d = '0;
                idx_d = idx_q + 3'd1;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                pat_q <= '0;
                per_q <= '0;
                cnt_q <= '0;
                idx_q <= '0;
                sig_q <= 1'b0;
            end else begin
                pat_q <= pat_d;
                per_q <= per_d;
                cnt_q <= cnt_d;
                idx_q <= idx_d;
                sig_q <= sig_d;
            end
        end

        assign signal[i] = sig_q;
    end

endmodule

// File: tb/tb_uart_multi_ctrl.sv
// Self-checking bench for uart_multi_ctrl with a behavioural channel model.
module tb_uart_multi_ctrl;

    localparam int unsigned BD  = 16;
    localparam int unsigned TMO = 400;
    localparam int unsigned NCH = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           uart_rx = 1'b1;
    logic [NCH-1:0] signal;
    logic           cmd_done;
    logic           frame_err;

    uart_multi_ctrl #(
        .CH_NUM       (NCH),
        .BAUD_DIV     (BD),
        .IDLE_TIMEOUT (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .uart_rx   (uart_rx),
        .signal    (signal),
        .cmd_done  (cmd_done),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    // Model: per channel, the committed pattern/period and the cmd_done cycle.
    logic [7:0]  m_pat [NCH];
    int unsigned m_per [NCH];
    longint      m_c   [NCH];
    int          n_cmd = 0;
    int          n_err = 0;
    longint      last_cmd_cyc = 0;
    bit          overlap = 1'b0;
    int          pend_seq = 0;
    int          applied_seq = 0;
    int          pend_ch = 0;
    logic [7:0]  pend_pat = '0;
    int unsigned pend_per = 0;

    always @(negedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                m_pat[i] = '0;
                m_per[i] = 0;
                m_c[i]   = 0;
            end
            applied_seq = pend_seq;
        end else begin
            if (cmd_done && frame_err) overlap = 1'b1;
            if (frame_err) n_err++;
            if (cmd_done) begin
                n_cmd++;
                last_cmd_cyc = cyc;
                if (applied_seq != pend_seq) begin
                    m_pat[pend_ch] = pend_pat;
                    m_per[pend_ch] = pend_per;
                    m_c[pend_ch]   = cyc;
                    applied_seq    = pend_seq;
                end
            end
        end
    end

    // Bit held for 'period' cycles each, LSB first, starting the cycle after cmd_done.
    function automatic logic model_sig(int ch, longint c);
        longint k;
        if (m_per[ch] == 0) return 1'b0;
        k = c - m_c[ch] - 1;
        return m_pat[ch][int'((k / longint'(m_per[ch])) % 8)];
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (BD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (BD) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (BD) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] ch, input logic [7:0] pat,
                              input logic [31:0] per, input logic [7:0] tail);
        logic [7:0] fr [9];
        fr[0] = 8'h55; fr[1] = 8'hA5; fr[2] = ch; fr[3] = pat;
        fr[4] = per[31:24]; fr[5] = per[23:16]; fr[6] = per[15:8]; fr[7] = per[7:0];
        fr[8] = tail;
        for (int i = 0; i < 9; i++) send_byte(fr[i], 1'b1);
    endtask

    task automatic expect_commit(input int ch, input logic [7:0] pat, input int unsigned per);
        pend_ch  = ch;
        pend_pat = pat;
        pend_per = per;
        pend_seq++;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if (signal !== '0) begin miscompares++; $display("FAIL reset_signal got=%b exp=0", signal); end
        vectors++;
        if (cmd_done !== 1'b0) begin miscompares++; $display("FAIL reset_cmd_done got=%b exp=0", cmd_done); end
        vectors++;
        if (frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        vectors++;
        if (signal !== '0) begin miscompares++; $display("FAIL post_reset_signal got=%b exp=0", signal); end
    endtask

    task automatic test_basic();
        int c0, e0;
        logic [7:0] seq;
        longint k;
        logic exp;
        seq = 8'hA5;
        c0 = n_cmd; e0 = n_err;
        expect_commit(1, 8'hA5, 3);
        send_frame(8'h01, 8'hA5, 32'd3, 8'hF0);
        @(negedge clk); #1;
        vectors++;
        if (n_cmd - c0 !== 1) begin miscompares++; $display("FAIL basic_cmd_done got=%0d exp=1", n_cmd - c0); end
        vectors++;
        if (n_err - e0 !== 0) begin miscompares++; $display("FAIL basic_frame_err got=%0d exp=0", n_err - e0); end
        for (int n = 0; n < 48; n++) begin
            @(negedge clk); #1;
            k = cyc - last_cmd_cyc - 1;
            exp = seq[int'((k / 3) % 8)];
            vectors++;
            if (signal !== {2'b00, exp, 1'b0}) begin
                miscompares++;
                $display("FAIL basic_signal cyc=%0d got=%b exp=%b", cyc, signal, {2'b00, exp, 1'b0});
            end
        end
    endtask

    task automatic test_bad_channel();
        int c0, e0;
        c0 = n_cmd; e0 = n_err;
        send_frame(8'h04, 8'hFF, 32'd2, 8'hF0);
        for (int n = 0; n < 30; n++) begin
            @(negedge clk); #1;
            for (int c = 0; c < NCH; c++) begin
                vectors++;
                if (signal[c] !== model_sig(c, cyc)) begin
                    miscompares++;
                    $display("FAIL badch_sig ch%0d cyc=%0d got=%b exp=%b", c, cyc, signal[c], model_sig(c, cyc));
                end
            end
        end
        vectors++;
        if (n_err - e0 !== 1) begin miscompares++; $display("FAIL badch_frame_err got=%0d exp=1", n_err - e0); end
        vectors++;
        if (n_cmd - c0 !== 0) begin miscompares++; $display("FAIL badch_cmd_done got=%0d exp=0", n_cmd - c0); end
    endtask

    task automatic test_bad_tail();
        int c0, e0;
        c0 = n_cmd; e0 = n_err;
        send_frame(8'h02, 8'h3C, 32'd5, 8'hF1);
        @(negedge clk); #1;
        vectors++;
        if (n_err - e0 !== 1) begin miscompares++; $display("FAIL badtail_frame_err got=%0d exp=1", n_err - e0); end
        vectors++;
        if (signal[2] !== model_sig(2, cyc)) begin miscompares++; $display("FAIL badtail_ch2 got=%b exp=%b", signal[2], model_sig(2, cyc)); end
        expect_commit(2, 8'h96, 2);
        send_frame(8'h02, 8'h96, 32'd2, 8'hF0);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk); #1;
            for (int c = 0; c < NCH; c++) begin
                vectors++;
                if (signal[c] !== model_sig(c, cyc)) begin
                    miscompares++;
                    $display("FAIL badtail_sig ch%0d cyc=%0d got=%b exp=%b", c, cyc, signal[c], model_sig(c, cyc));
                end
            end
        end
        vectors++;
        if (n_cmd - c0 !== 1) begin miscompares++; $display("FAIL badtail_cmd_done got=%0d exp=1", n_cmd - c0); end
        vectors++;
        if (n_err - e0 !== 1) begin miscompares++; $display("FAIL badtail_err_total got=%0d exp=1", n_err - e0); end
    endtask

    task automatic test_stop_err();
        int c0, e0;
        logic [7:0] pat;
        int unsigned per;
        c0 = n_cmd; e0 = n_err;
        send_byte(8'h55, 1'b1);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b0);
        repeat (20) @(negedge clk);
        #1;
        vectors++;
        if (n_err - e0 !== 1) begin miscompares++; $display("FAIL stoperr_frame_err got=%0d exp=1", n_err - e0); end
        pat = 8'($urandom);
        per = $urandom_range(1, 6);
        expect_commit(0, pat, per);
        send_byte(8'h55, 1'b1);
        send_frame(8'h00, pat, per, 8'hF0);
        for (int n = 0; n < 60; n++) begin
            @(negedge clk); #1;
            for (int c = 0; c < NCH; c++) begin
                vectors++;
                if (signal[c] !== model_sig(c, cyc)) begin
                    miscompares++;
                    $display("FAIL stoperr_sig ch%0d cyc=%0d got=%b exp=%b", c, cyc, signal[c], model_sig(c, cyc));
                end
            end
        end
        vectors++;
        if (n_cmd - c0 !== 1) begin miscompares++; $display("FAIL stoperr_cmd_done got=%0d exp=1", n_cmd - c0); end
        vectors++;
        if (n_err - e0 !== 1) begin miscompares++; $display("FAIL stoperr_err_total got=%0d exp=1", n_err - e0); end
    endtask

    task automatic test_timeout();
        int c0, e0;
        logic [7:0] pat;
        int unsigned per;
        c0 = n_cmd; e0 = n_err;
        send_byte(8'h55, 1'b1);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h81, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (500) @(negedge clk);
        #1;
        vectors++;
        if (n_err - e0 !== 1) begin miscompares++; $display("FAIL timeout_frame_err got=%0d exp=1", n_err - e0); end
        vectors++;
        if (n_cmd - c0 !== 0) begin miscompares++; $display("FAIL timeout_cmd_done got=%0d exp=0", n_cmd - c0); end
        pat = 8'($urandom);
        per = $urandom_range(1, 5);
        expect_commit(3, pat, per);
        send_frame(8'h03, pat, per, 8'hF0);
        for (int n = 0; n < 50; n++) begin
            @(negedge clk); #1;
            for (int c = 0; c < NCH; c++) begin
                vectors++;
                if (signal[c] !== model_sig(c, cyc)) begin
                    miscompares++;
                    $display("FAIL timeout_sig ch%0d cyc=%0d got=%b exp=%b", c, cyc, signal[c], model_sig(c, cyc));
                end
            end
        end
        vectors++;
        if (n_cmd - c0 !== 1) begin miscompares++; $display("FAIL timeout_recommit got=%0d exp=1", n_cmd - c0); end
    endtask

    task automatic test_glitch();
        int c0, e0;
        c0 = n_cmd; e0 = n_err;
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        vectors++;
        if (n_err - e0 !== 0) begin miscompares++; $display("FAIL glitch_frame_err got=%0d exp=0", n_err - e0); end
        vectors++;
        if (n_cmd - c0 !== 0) begin miscompares++; $display("FAIL glitch_cmd_done got=%0d exp=0", n_cmd - c0); end
    endtask

    task automatic test_back_to_back();
        int c0;
        c0 = n_cmd;
        expect_commit(0, 8'h6D, 2);
        send_frame(8'h00, 8'h6D, 32'd2, 8'hF0);
        expect_commit(2, 8'hC3, 1);
        send_frame(8'h02, 8'hC3, 32'd1, 8'hF0);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk); #1;
            for (int c = 0; c < NCH; c++) begin
                vectors++;
                if (signal[c] !== model_sig(c, cyc)) begin
                    miscompares++;
                    $display("FAIL b2b_sig ch%0d cyc=%0d got=%b exp=%b", c, cyc, signal[c], model_sig(c, cyc));
                end
            end
        end
        vectors++;
        if (n_cmd - c0 !== 2) begin miscompares++; $display("FAIL b2b_cmd_done got=%0d exp=2", n_cmd - c0); end
    endtask

    task automatic test_random();
        int c0, e0, ch;
        logic [7:0] pat;
        int unsigned per;
        for (int it = 0; it < 6; it++) begin
            c0 = n_cmd; e0 = n_err;
            ch  = int'($urandom_range(0, NCH - 1));
            pat = 8'($urandom);
            per = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 9);
            expect_commit(ch, pat, per);
            send_frame(8'(ch), pat, per, 8'hF0);
            for (int n = 0; n < 80; n++) begin
                @(negedge clk); #1;
                for (int c = 0; c < NCH; c++) begin
                    vectors++;
                    if (signal[c] !== model_sig(c, cyc)) begin
                        miscompares++;
                        $display("FAIL rand%0d_sig ch%0d cyc=%0d got=%b exp=%b", it, c, cyc, signal[c], model_sig(c, cyc));
                    end
                end
            end
            vectors++;
            if (n_cmd - c0 !== 1 || n_err - e0 !== 0) begin
                miscompares++;
                $display("FAIL rand%0d_counts cmd=%0d err=%0d exp cmd=1 err=0", it, n_cmd - c0, n_err - e0);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int c0, e0;
        send_byte(8'h55, 1'b1);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h00, 1'b1);
        uart_rx = 1'b0;
        repeat (BD + BD / 2) @(negedge clk);
        for (int n = 0; n < 30 && signal == '0; n++) @(negedge clk);
        reset = 1'b1;
        #1;
        vectors++;
        if (signal !== '0) begin miscompares++; $display("FAIL midreset_signal got=%b exp=0", signal); end
        vectors++;
        if (cmd_done !== 1'b0 || frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_pulses cmd_done=%b frame_err=%b exp 0 0", cmd_done, frame_err);
        end
        uart_rx = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        c0 = n_cmd; e0 = n_err;
        expect_commit(3, 8'hFF, 0);
        send_frame(8'h03, 8'hFF, 32'd0, 8'hF0);
        for (int n = 0; n < 30; n++) begin
            @(negedge clk); #1;
            vectors++;
            if (signal !== '0) begin
                miscompares++;
                $display("FAIL midreset_after_signal cyc=%0d got=%b exp=0", cyc, signal);
            end
        end
        vectors++;
        if (n_cmd - c0 !== 1) begin miscompares++; $display("FAIL midreset_cmd_done got=%0d exp=1", n_cmd - c0); end
        vectors++;
        if (n_err - e0 !== 0) begin miscompares++; $display("FAIL midreset_frame_err got=%0d exp=0", n_err - e0); end
    endtask

    task automatic test_exclusive();
        vectors++;
        if (overlap !== 1'b0) begin miscompares++; $display("FAIL pulse_overlap got=%b exp=0", overlap); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_channel();
        test_bad_tail();
        test_stop_err();
        test_timeout();
        test_glitch();
        test_back_to_back();
        test_random();
        test_reset_midframe();
        test_exclusive();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_multi_ctrl.md
UART_MULTI_CTRL -- requirements
Module: uart_multi_ctrl

Interface
REQ-001 SHALL have parameter CH_NUM, default 4, number of independent output channels (legal range 1..16).
REQ-002 SHALL have parameter BAUD_DIV, default 434, clk cycles per UART bit (50 MHz / 115200).
REQ-003 SHALL have parameter IDLE_TIMEOUT, default 50000, clk cycles of inter-byte silence that abort a partial frame.
REQ-004 SHALL have port clk, input, 1 bit, the single system clock.
REQ-005 SHALL have port reset, input, 1 bit; one clock, and reset is asynchronous and active-high.
REQ-006 SHALL have port uart_rx, input, 1 bit, asynchronous serial line, 8N1, idle high.
REQ-007 SHALL have port signal, output, CH_NUM bits, per-channel pattern output, registered.
REQ-008 SHALL have port cmd_done, output, 1 bit, one-cycle pulse when a valid frame is committed.
REQ-009 SHALL have port frame_err, output, 1 bit, one-cycle pulse when a byte or frame is rejected.

Function
REQ-010 SHALL synchronise uart_rx through two flops before any use.
REQ-011 SHALL detect a start bit on a synchronised 1->0 edge, re-check low at BAUD_DIV/2, and abort to idle without error if high.
REQ-012 SHALL sample data bits LSB first at bit centres (every BAUD_DIV cycles after the start-bit centre).
REQ-013 SHALL accept a byte only if the stop-bit sample is 1; otherwise drop the byte and pulse frame_err.
REQ-014 SHALL parse a 9-byte frame: 0x55, 0xA5, ch_id, pattern[7:0], time[31:24], time[23:16], time[15:8], time[7:0], 0xF0.
REQ-015 SHALL use parser states IDLE, HDR2, CH, PAT, T3, T2, T1, T0, TAIL.
REQ-016 SHALL move from IDLE to HDR2 only on 0x55 and stay in IDLE on any other byte.
REQ-017 SHALL, in HDR2, advance on 0xA5, stay in HDR2 on 0x55, and return to IDLE on any other byte (no frame_err).
REQ-018 SHALL, in TAIL, commit on 0xF0; otherwise discard the frame, pulse frame_err, and return to IDLE.
REQ-019 SHALL, when ch_id >= CH_NUM, complete the frame but on a good tail discard it and pulse frame_err instead of cmd_done.
REQ-020 SHALL, when no byte is received for IDLE_TIMEOUT cycles in any state other than IDLE, return the parser to IDLE and pulse frame_err.
REQ-021 SHALL, on commit, load the channel's pattern and time registers and pulse cmd_done in the same cycle (one cycle after the tail byte's stop-bit sample).
REQ-022 SHALL run each channel as a step counter of period time, output pattern[idx] with idx from 0 to 7, advance idx every time cycles, and wrap idx from 7 to 0.
REQ-023 SHALL, on commit, reset the target channel's counter and idx so that signal[ch] = pattern[0] from the cycle after cmd_done.
REQ-024 SHALL treat time = 0 as disabled: signal[ch] = 0 and the counter held at 0.
REQ-025 SHALL compare the 32-bit counter as (cnt == time-1) and never overflow.
REQ-026 SHALL leave channels not addressed by a commit undisturbed, with no phase glitch.
REQ-027 SHALL never pulse cmd_done and frame_err in the same cycle.

Reset
REQ-028 SHALL, on reset assertion, immediately force signal=0, cmd_done=0, frame_err=0, all patterns=0, all times=0, parser=IDLE, and receiver=idle.
REQ-029 SHALL, on reset during reception, discard the partial byte and frame; the next frame after release is received normally.
REQ-030 SHALL reset synchroniser flops to 1 (line idle).

Structure
REQ-031 SHALL place HDR0=0x55, HDR1=0xA5, TAIL=0xF0, the parser state encoding, and FRAME_LEN=9 in the shared package uart_ctrl_pkg.
REQ-032 SHALL implement the byte receiver as sub-module uart_rx_core (ports clk, reset, rx, BAUD_DIV parameter, outputs data[7:0], valid, err).
REQ-033 SHALL implement the parser and CH_NUM channel counters (generate loop) in uart_multi_ctrl.

Verification (bench: BAUD_DIV=16, IDLE_TIMEOUT=400, CH_NUM=4)
REQ-034 SHALL check: frame 55 A5 01 A5 00 00 00 03 F0 -> cmd_done pulses once; signal[1] = 1,0,1,0,0,1,0,1 per 3-cycle step and repeats; signal[0,2,3] stay 0.
REQ-035 SHALL check: ch_id=04 with a good tail -> frame_err pulses once, no cmd_done, all signals unchanged.
REQ-036 SHALL check: tail byte 0xF1 -> frame_err pulses, the channel is not updated; an immediately following valid frame commits.
REQ-037 SHALL check: stop bit driven 0 on byte 3 -> frame_err pulses; the stream 55 55 A5 ... then resyncs and commits.
REQ-038 SHALL check: 5 bytes sent, then 500 cycles idle -> frame_err pulses once at timeout; the next full frame commits.
REQ-039 SHALL check: reset asserted mid byte 6 -> signal=0 immediately; after release a new frame with time=0 keeps the channel at 0 and cmd_done pulses.
